alu_exec_unit: RTL and testbench

- Execute-stage datapath slice of the single-cycle RISC-V core. It bundles the ALU-control decoder, the WIDTH-bit ALU with zero flag, and the two PC adders (PC+4 and PC+imm branch target).
- It selects the next PC from the branch decision.
- All outputs are registered: one-cycle latency from the input-sampling edge.

---
 rtl/alu_exec_unit_if.sv | 34 +++
 rtl/alu_exec_unit.sv | 158 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Execute-stage bus for alu_exec_unit: operand/control inputs and registered results.
// The master modport drives operands and controls; the slave modport is the execute unit.
interface alu_exec_unit_if #(
   parameter int unsigned WIDTH = 64
);
   logic             in_valid;
   logic [1:0]       alu_op;
   logic [2:0]       func3;
   logic [6:0]       func7;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] imm;
   logic             branch;

   logic             out_valid;
   logic [3:0]       alu_c;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic [WIDTH-1:0] pc_plus4;
   logic [WIDTH-1:0] branch_target;
   logic [WIDTH-1:0] next_pc;
   logic             overflow;

   modport master (
      output in_valid, alu_op, func3, func7, in1, in2, pc, imm, branch,
      input  out_valid, alu_c, result, zero, pc_plus4, branch_target, next_pc, overflow
   );

   modport slave (
      input  in_valid, alu_op, func3, func7, in1, in2, pc, imm, branch,
      output out_valid, alu_c, result, zero, pc_plus4, branch_target, next_pc, overflow
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage slice: ALU-control decode, WIDTH-bit ALU, PC+PC_INC and PC+imm adders,
// next-PC select. All outputs registered (one-cycle latency).
// Optional macro ALU_OVERFLOW_EN builds signed overflow detection for ADD/SUB;
// without it overflow is tied to 0.
module alu_exec_unit #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned PC_INC = 4
) (
   input logic           Clk,
   input logic           En,
   alu_exec_unit_if.slave bus
);

   localparam int unsigned ShW = (WIDTH == 64) ? 6 : 5;

   localparam logic [3:0] CtlAnd  = 4'b0000;
   localparam logic [3:0] CtlOr   = 4'b0001;
   localparam logic [3:0] CtlAdd  = 4'b0010;
   localparam logic [3:0] CtlXor  = 4'b0011;
   localparam logic [3:0] CtlSll  = 4'b0100;
   localparam logic [3:0] CtlSrl  = 4'b0101;
   localparam logic [3:0] CtlSub  = 4'b0110;
   localparam logic [3:0] CtlSra  = 4'b0111;
   localparam logic [3:0] CtlSlt  = 4'b1000;
   localparam logic [3:0] CtlSltu = 4'b1001;

   logic [3:0]       alu_ctrl;
   logic [ShW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;
   logic             zero_comb;
   logic [WIDTH-1:0] pc_plus4_comb;
   logic [WIDTH-1:0] branch_target_comb;
   logic [WIDTH-1:0] next_pc_comb;

   logic             out_valid_q;
   logic [3:0]       alu_c_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic [WIDTH-1:0] pc_plus4_q;
   logic [WIDTH-1:0] branch_target_q;
   logic [WIDTH-1:0] next_pc_q;

   // Only instruction[30] of func7 matters.
   logic unused_func7;
   assign unused_func7 = ^{bus.func7[6], bus.func7[4:0]};

   // Decode alu_op/func3/func7[5] into the 4-bit ALU control code.
   always_comb begin
      alu_ctrl = CtlAdd;
      unique case (bus.alu_op)
         2'b00: alu_ctrl = CtlAdd;
         2'b01: alu_ctrl = CtlSub;
         2'b10, 2'b11: begin
            unique case (bus.func3)
               // I-type has no SUBI; func7[5] there is part of the immediate.
               3'b000: alu_ctrl = (bus.alu_op == 2'b10 && bus.func7[5]) ? CtlSub : CtlAdd;
               3'b001: alu_ctrl = CtlSll;
               3'b010: alu_ctrl = CtlSlt;
               3'b011: alu_ctrl = CtlSltu;
               3'b100: alu_ctrl = CtlXor;
               3'b101: alu_ctrl = bus.func7[5] ? CtlSra : CtlSrl;
               3'b110: alu_ctrl = CtlOr;
               3'b111: alu_ctrl = CtlAnd;
               default: alu_ctrl = CtlAdd;
            endcase
         end
         default: alu_ctrl = CtlAdd;
      endcase
   end

   assign shamt = bus.in2[ShW-1:0];

   // ALU datapath; unused control codes produce 0.
   always_comb begin
      alu_res = '0;
      case (alu_ctrl)
         CtlAnd:  alu_res = bus.in1 & bus.in2;
         CtlOr:   alu_res = bus.in1 | bus.in2;
         CtlAdd:  alu_res = bus.in1 + bus.in2;
         CtlXor:  alu_res = bus.in1 ^ bus.in2;
         CtlSll:  alu_res = bus.in1 << shamt;
         CtlSrl:  alu_res = bus.in1 >> shamt;
         CtlSub:  alu_res = bus.in1 - bus.in2;
         CtlSra:  alu_res = $signed(bus.in1) >>> shamt;
         CtlSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.in1) < $signed(bus.in2)};
         CtlSltu: alu_res = {{(WIDTH-1){1'b0}}, bus.in1 < bus.in2};
         default: alu_res = '0;
      endcase
   end

   assign zero_comb          = (alu_res == '0);
   assign pc_plus4_comb      = bus.pc + WIDTH'(PC_INC);
   assign branch_target_comb = bus.pc + bus.imm;
   assign next_pc_comb       = (bus.branch && zero_comb) ? branch_target_comb : pc_plus4_comb;

   // Output registers: load on in_valid, hold otherwise; out_valid follows in_valid.
   always_ff @(posedge Clk or negedge En) begin
      if (!En) begin
         out_valid_q     <= 1'b0;
         alu_c_q         <= '0;
         result_q        <= '0;
         zero_q          <= 1'b0;
         pc_plus4_q      <= '0;
         branch_target_q <= '0;
         next_pc_q       <= '0;
      end else begin
         out_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            alu_c_q         <= alu_ctrl;
            result_q        <= alu_res;
            zero_q          <= zero_comb;
            pc_plus4_q      <= pc_plus4_comb;
            branch_target_q <= branch_target_comb;
            next_pc_q       <= next_pc_comb;
         end
      end
   end

`ifdef ALU_OVERFLOW_EN
   logic ovf_comb;
   logic ovf_q;

   // Signed overflow: ADD when operand signs agree and result sign differs,
   // SUB when operand signs differ and result sign differs from in1.
   always_comb begin
      ovf_comb = 1'b0;
      if (alu_ctrl == CtlAdd) begin
         ovf_comb = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) &&
                    (alu_res[WIDTH-1] != bus.in1[WIDTH-1]);
      end else if (alu_ctrl == CtlSub) begin
         ovf_comb = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &&
                    (alu_res[WIDTH-1] != bus.in1[WIDTH-1]);
      end
   end

   // Overflow register shares the load/hold behaviour of the other data outputs.
   always_ff @(posedge Clk or negedge En) begin
      if (!En) begin
         ovf_q <= 1'b0;
      end else if (bus.in_valid) begin
         ovf_q <= ovf_comb;
      end
   end

   assign bus.overflow = ovf_q;
`else
   assign bus.overflow = 1'b0;
`endif

   assign bus.out_valid     = out_valid_q;
   assign bus.alu_c         = alu_c_q;
   assign bus.result        = result_q;
   assign bus.zero          = zero_q;
   assign bus.pc_plus4      = pc_plus4_q;
   assign bus.branch_target = branch_target_q;
   assign bus.next_pc       = next_pc_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit (WIDTH=64): directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_alu_exec_unit;

   logic Clk = 1'b0;
   logic En  = 1'b0;

   alu_exec_unit_if #(.WIDTH(64)) bus ();

   alu_exec_unit #(.WIDTH(64), .PC_INC(4)) dut (
      .Clk(Clk),
      .En (En),
      .bus(bus)
   );

   always #5 Clk = ~Clk;

   int n_pass  = 0;
   int n_total = 0;

   // Model state: what the registered outputs must show.
   logic        exp_valid = 1'b0;
   logic [3:0]  exp_code  = '0;
   logic [63:0] exp_res   = '0;
   logic        exp_zero  = 1'b0;
   logic [63:0] exp_p4    = '0;
   logic [63:0] exp_bt    = '0;
   logic [63:0] exp_npc   = '0;
   logic        exp_ovf   = 1'b0;

   typedef enum int {MAdd, MSub, MSll, MSlt, MSltu, MXor, MSrl, MSra, MOr, MAnd} mop_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%016h, expected 0x%016h at %0t", name, act, req, $time);
   endtask

   // Behavioural reference: pick the operation by name, then evaluate it arithmetically.
   function automatic void model(input logic [1:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [63:0] a,
                                 input logic [63:0] b, output logic [3:0] code,
                                 output logic [63:0] r, output logic ovf);
      mop_e        m;
      logic [64:0] wide;
      int unsigned sh;
      if (op == 2'b00) m = MAdd;
      else if (op == 2'b01) m = MSub;
      else begin
         case (f3)
            3'd0: m = (op == 2'b10 && f7[5]) ? MSub : MAdd;
            3'd1: m = MSll;
            3'd2: m = MSlt;
            3'd3: m = MSltu;
            3'd4: m = MXor;
            3'd5: m = f7[5] ? MSra : MSrl;
            3'd6: m = MOr;
            default: m = MAnd;
         endcase
      end
      sh   = int'(b % 64);
      ovf  = 1'b0;
      r    = '0;
      code = 4'd0;
      case (m)
         MAdd: begin
            code = 4'd2; r = a + b;
            wide = {a[63], a} + {b[63], b};
            ovf  = wide[64] != wide[63];
         end
         MSub: begin
            code = 4'd6; r = a - b;
            wide = {a[63], a} - {b[63], b};
            ovf  = wide[64] != wide[63];
         end
         MSll:  begin code = 4'd4; r = a << sh; end
         MSrl:  begin code = 4'd5; r = a >> sh; end
         MSra:  begin code = 4'd7; r = 64'(longint'(a) >>> sh); end
         MSlt:  begin code = 4'd8; r = (longint'(a) < longint'(b)) ? 64'd1 : 64'd0; end
         MSltu: begin code = 4'd9; r = (a < b) ? 64'd1 : 64'd0; end
         MXor:  begin code = 4'd3; r = a ^ b; end
         MOr:   begin code = 4'd1; r = a | b; end
         MAnd:  begin code = 4'd0; r = a & b; end
         default: begin code = 4'd0; r = '0; end
      endcase
`ifndef ALU_OVERFLOW_EN
      ovf = 1'b0;
`endif
   endfunction

   // Model update at each edge (or reset), then compare all outputs shortly after.
   always @(posedge Clk or negedge En) begin
      logic [3:0]  c;
      logic [63:0] r;
      logic        o;
      if (!En) begin
         exp_valid = 0; exp_code = '0; exp_res = '0; exp_zero = 0;
         exp_p4 = '0; exp_bt = '0; exp_npc = '0; exp_ovf = 0;
      end else begin
         exp_valid = bus.in_valid;
         if (bus.in_valid) begin
            model(bus.alu_op, bus.func3, bus.func7, bus.in1, bus.in2, c, r, o);
            exp_code = c;
            exp_res  = r;
            exp_zero = (r == 0);
            exp_ovf  = o;
            exp_p4   = bus.pc + 64'd4;
            exp_bt   = bus.pc + bus.imm;
            exp_npc  = (bus.branch && r == 0) ? exp_bt : exp_p4;
         end
      end
      #1;
      chk("cyc_out_valid", 64'(bus.out_valid), 64'(exp_valid));
      chk("cyc_alu_c", 64'(bus.alu_c), 64'(exp_code));
      chk("cyc_result", bus.result, exp_res);
      chk("cyc_zero", 64'(bus.zero), 64'(exp_zero));
      chk("cyc_pc_plus4", bus.pc_plus4, exp_p4);
      chk("cyc_branch_target", bus.branch_target, exp_bt);
      chk("cyc_next_pc", bus.next_pc, exp_npc);
      chk("cyc_overflow", 64'(bus.overflow), 64'(exp_ovf));
   end

   task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] p, input logic [63:0] i, input logic br);
      @(negedge Clk);
      bus.in_valid = v;  bus.alu_op = op; bus.func3 = f3; bus.func7 = f7;
      bus.in1      = a;  bus.in2    = b;  bus.pc    = p;  bus.imm   = i;
      bus.branch   = br;
   endtask

   task automatic settle;
      @(posedge Clk);
      #2;
   endtask

   // Check DUT and model result against a hand-computed literal.
   task automatic lit(input string name, input logic [63:0] req);
      chk({name, "_dut"}, bus.result, req);
      chk({name, "_model"}, exp_res, req);
   endtask

   logic [63:0] ra, rb;

   initial begin
      bus.in_valid = 0; bus.alu_op = 0; bus.func3 = 0; bus.func7 = 0;
      bus.in1 = 0; bus.in2 = 0; bus.pc = 0; bus.imm = 0; bus.branch = 0;
      repeat (2) @(posedge Clk);
      #1;
      chk("reset_zero_flag", 64'(bus.zero), 64'd0);

      // Load something, then reset asynchronously mid-cycle.
      @(negedge Clk) En = 1'b1;
      drive(1, 2'b00, 3'd0, 7'd0, 64'd9, 64'd9, 64'h80, 64'h0, 1'b0);
      settle();
      chk("preload_result", bus.result, 64'd18);
      #1 En = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("async_rst_result", bus.result, 64'd0);
      chk("async_rst_pc_plus4", bus.pc_plus4, 64'd0);
      chk("async_rst_next_pc", bus.next_pc, 64'd0);
      chk("async_rst_alu_c", 64'(bus.alu_c), 64'd0);
      @(negedge Clk) En = 1'b1;

      drive(1, 2'b00, 3'd0, 7'd0, 64'd5, 64'd7, 64'h100, 64'h0, 1'b0);
      settle();
      lit("add_5_7", 64'd12);
      chk("add_zero", 64'(bus.zero), 64'd0);
      chk("add_alu_c", 64'(bus.alu_c), 64'b0010);
      chk("add_pc_plus4", bus.pc_plus4, 64'h104);
      chk("add_next_pc", bus.next_pc, 64'h104);
      chk("add_out_valid", 64'(bus.out_valid), 64'd1);

      drive(1, 2'b01, 3'd0, 7'd0, 64'h55, 64'h55, 64'h200, 64'h40, 1'b1);
      settle();
      lit("beq_taken", 64'd0);
      chk("beq_zero", 64'(bus.zero), 64'd1);
      chk("beq_target", bus.branch_target, 64'h240);
      chk("beq_next_pc", bus.next_pc, 64'h240);
      drive(1, 2'b01, 3'd0, 7'd0, 64'h55, 64'h56, 64'h200, 64'h40, 1'b1);
      settle();
      chk("beq_not_taken_next_pc", bus.next_pc, 64'h204);

      drive(1, 2'b10, 3'd7, 7'h00, 64'hF0, 64'h3C, 64'h0, 64'h0, 1'b0); settle();
      lit("r_and", 64'h30);
      drive(1, 2'b10, 3'd6, 7'h00, 64'hF0, 64'h3C, 64'h0, 64'h0, 1'b0); settle();
      lit("r_or", 64'hFC);
      drive(1, 2'b10, 3'd4, 7'h00, 64'hF0, 64'h3C, 64'h0, 64'h0, 1'b0); settle();
      lit("r_xor", 64'hCC);
      drive(1, 2'b10, 3'd0, 7'h20, 64'hF0, 64'h3C, 64'h0, 64'h0, 1'b0); settle();
      lit("r_sub", 64'hB4);
      chk("r_sub_alu_c", 64'(bus.alu_c), 64'b0110);

      drive(1, 2'b10, 3'd5, 7'h00, 64'h8000_0000_0000_0000, 64'd4, 64'h0, 64'h0, 1'b0);
      settle();
      lit("srl", 64'h0800_0000_0000_0000);
      drive(1, 2'b10, 3'd5, 7'h20, 64'h8000_0000_0000_0000, 64'd4, 64'h0, 64'h0, 1'b0);
      settle();
      lit("sra", 64'hF800_0000_0000_0000);
      drive(1, 2'b10, 3'd1, 7'h00, 64'd1, 64'd65, 64'h0, 64'h0, 1'b0); settle();
      lit("sll_masked_shamt", 64'd2);
      drive(1, 2'b10, 3'd2, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 64'h0, 1'b0);
      settle();
      lit("slt", 64'd1);
      drive(1, 2'b10, 3'd3, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 64'h0, 1'b0);
      settle();
      lit("sltu", 64'd0);

      drive(1, 2'b11, 3'd0, 7'h20, 64'd10, 64'd3, 64'h0, 64'h0, 1'b0); settle();
      lit("addi_f7", 64'd13);
      drive(0, 2'b10, 3'd0, 7'h20, 64'd1, 64'd1, 64'h0, 64'h0, 1'b0); settle();
      chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
      chk("idle_hold_result", bus.result, 64'd13);

      drive(1, 2'b00, 3'd0, 7'h00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 64'h0, 1'b0);
      settle();
      lit("add_ovf", 64'h8000_0000_0000_0000);
`ifdef ALU_OVERFLOW_EN
      chk("add_ovf_flag", 64'(bus.overflow), 64'd1);
`else
      chk("add_ovf_flag", 64'(bus.overflow), 64'd0);
`endif

      // Randomized traffic; the per-cycle compare process does the checking.
      for (int n = 0; n < 400; n++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: rb = ra;
            1: rb = 64'($urandom_range(0, 127));
            2: ra = 64'h7FFF_FFFF_FFFF_FFFF;
            3: ra = 64'h8000_0000_0000_0000;
            default: ;
         endcase
         drive(($urandom_range(0, 4) != 0), 2'($urandom), 3'($urandom), 7'($urandom),
               ra, rb, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      end

      drive(0, 2'b00, 3'd0, 7'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
      settle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
